// File: rtl/mem_lsu_ysyx23060136_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM states, func3 size codes, AXI resp codes.
package mem_lsu_ysyx23060136_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWreq,
        StWresp,
        StDone
    } lsu_state_e;

    localparam logic [2:0] Func3B  = 3'b000;
    localparam logic [2:0] Func3H  = 3'b001;
    localparam logic [2:0] Func3W  = 3'b010;
    localparam logic [2:0] Func3Bu = 3'b100;
    localparam logic [2:0] Func3Hu = 3'b101;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespExokay = 2'b01;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

endpackage

// File: rtl/mem_lsu_ysyx23060136_align.sv
// Byte-lane steering: store data replication and strobes, load lane extraction and extension.
module mem_align_ysyx23060136
    import mem_lsu_ysyx23060136_pkg::*;
(
    input  logic [2:0]  i_func3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_ld_raw[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];

        o_wdata = i_st_data;
        o_wstrb = 4'b1111;
        case (i_func3[1:0])
            2'b00: begin
                o_wdata = {4{i_st_data[7:0]}};
                o_wstrb = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wdata = {2{i_st_data[15:0]}};
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            default: ;
        endcase

        o_ld_data = i_ld_raw;
        case (i_func3)
            Func3B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            Func3H:  o_ld_data = {{16{w_half[15]}}, w_half};
            Func3Bu: o_ld_data = {24'h0, w_byte};
            Func3Hu: o_ld_data = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_lsu_ysyx23060136.sv
// MEM-stage load/store unit: one outstanding AXI4-Lite read or write per MEM instruction.
module mem_lsu_ysyx23060136
    import mem_lsu_ysyx23060136_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_i_mem_to_reg,
    input  logic              MEM_i_write_mem,
    input  logic [2:0]        MEM_i_func3,
    input  logic [ADDR_W-1:0] MEM_i_ALU_ALUout,
    input  logic [DATA_W-1:0] MEM_i_rs2_data,
    input  logic              FORWARD_stallME,
    output logic              MEM_rvalid,
    output logic              MEM_wready,
    output logic [DATA_W-1:0] MEM_o_rdata,
    output logic              arvalid,
    input  logic              arready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] awaddr,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] wdata,
    output logic [3:0]        wstrb,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp
);

    lsu_state_e        r_state, w_state_d;
    logic [DATA_W-1:0] r_rdata, r_wdata;
    logic [ADDR_W-1:0] r_araddr, r_awaddr;
    logic [3:0]        r_wstrb;
    logic [2:0]        r_func3;
    logic [1:0]        r_addr_lo;
    logic              r_aw_done, r_w_done;

    logic              w_idle, w_aw_ok, w_w_ok;
    logic [2:0]        w_al_func3;
    logic [1:0]        w_al_addr_lo;
    logic [DATA_W-1:0] w_st_wdata, w_ld_data;
    logic [3:0]        w_st_wstrb;
    logic              w_unused;

    // Bus errors are not reported to the pipeline.
    assign w_unused = ^{rresp, bresp};

    assign w_idle = (r_state == StIdle);

    // Live operands steer the store lanes in IDLE; the latched ones steer load extraction later.
    assign w_al_func3   = w_idle ? MEM_i_func3 : r_func3;
    assign w_al_addr_lo = w_idle ? MEM_i_ALU_ALUout[1:0] : r_addr_lo;

    mem_align_ysyx23060136 u_align (
        .i_func3   (w_al_func3),
        .i_addr_lo (w_al_addr_lo),
        .i_st_data (MEM_i_rs2_data),
        .i_ld_raw  (rdata),
        .o_wdata   (w_st_wdata),
        .o_wstrb   (w_st_wstrb),
        .o_ld_data (w_ld_data)
    );

    assign arvalid     = (r_state == StRaddr);
    assign rready      = (r_state == StRdata);
    assign awvalid     = (r_state == StWreq) & ~r_aw_done;
    assign wvalid      = (r_state == StWreq) & ~r_w_done;
    assign bready      = (r_state == StWresp);
    assign araddr      = r_araddr;
    assign awaddr      = r_awaddr;
    assign wdata       = r_wdata;
    assign wstrb       = r_wstrb;
    assign MEM_o_rdata = r_rdata;
    assign MEM_rvalid  = ~MEM_i_mem_to_reg | (r_state == StDone);
    assign MEM_wready  = ~MEM_i_write_mem | (r_state == StDone);

    assign w_aw_ok = r_aw_done | (awvalid & awready);
    assign w_w_ok  = r_w_done | (wvalid & wready);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle: begin
                if (MEM_i_mem_to_reg)     w_state_d = StRaddr;
                else if (MEM_i_write_mem) w_state_d = StWreq;
            end
            StRaddr: if (arready)            w_state_d = StRdata;
            StRdata: if (rvalid)             w_state_d = StDone;
            StWreq:  if (w_aw_ok && w_w_ok)  w_state_d = StWresp;
            StWresp: if (bvalid)             w_state_d = StDone;
            StDone:  if (!FORWARD_stallME)   w_state_d = StIdle;
            default:                         w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_rdata   <= '0;
            r_araddr  <= '0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_func3   <= '0;
            r_addr_lo <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_idle && MEM_i_mem_to_reg) begin
                r_araddr  <= {MEM_i_ALU_ALUout[ADDR_W-1:2], 2'b00};
                r_func3   <= MEM_i_func3;
                r_addr_lo <= MEM_i_ALU_ALUout[1:0];
            end else if (w_idle && MEM_i_write_mem) begin
                r_awaddr  <= {MEM_i_ALU_ALUout[ADDR_W-1:2], 2'b00};
                r_wdata   <= w_st_wdata;
                r_wstrb   <= w_st_wstrb;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (awvalid && awready) r_aw_done <= 1'b1;
            if (wvalid && wready)   r_w_done  <= 1'b1;
            if (rready && rvalid)   r_rdata   <= w_ld_data;
        end
    end

endmodule

// File: tb/tb_mem_lsu_ysyx23060136.sv
// Self-checking bench for mem_lsu_ysyx23060136 with a scoreboard queue of expected bus/load values.
module tb_mem_lsu_ysyx23060136;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_to_reg, write_mem, stall;
    logic [2:0]  func3;
    logic [31:0] alu_out, rs2;
    logic        mem_rvalid, mem_wready;
    logic [31:0] mem_rdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    mem_lsu_ysyx23060136 dut (
        .clk              (clk),
        .rst              (rst),
        .MEM_i_mem_to_reg (mem_to_reg),
        .MEM_i_write_mem  (write_mem),
        .MEM_i_func3      (func3),
        .MEM_i_ALU_ALUout (alu_out),
        .MEM_i_rs2_data   (rs2),
        .FORWARD_stallME  (stall),
        .MEM_rvalid       (mem_rvalid),
        .MEM_wready       (mem_wready),
        .MEM_o_rdata      (mem_rdata),
        .arvalid          (arvalid),
        .arready          (arready),
        .araddr           (araddr),
        .rvalid           (rvalid),
        .rready           (rready),
        .rdata            (rdata),
        .rresp            (rresp),
        .awvalid          (awvalid),
        .awready          (awready),
        .awaddr           (awaddr),
        .wvalid           (wvalid),
        .wready           (wready),
        .wdata            (wdata),
        .wstrb            (wstrb),
        .bvalid           (bvalid),
        .bready           (bready),
        .bresp            (bresp)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty got=%h exp=<none>", got);
        end else begin
            t = q_tag.pop_front();
            e = q_exp.pop_front();
            check_eq(t, got, e);
        end
    endtask

    task automatic idle_inputs();
        mem_to_reg = 0; write_mem = 0; stall = 0; func3 = 3'b010;
        alu_out = 0; rs2 = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
    endtask

    // Zero-wait slave; returns after DONE -> IDLE.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] data, input logic [31:0] exp);
        int cyc;
        arready = 1; rvalid = 1; rdata = data; rresp = 2'b10;
        alu_out = addr; func3 = f3; mem_to_reg = 1;
        push_exp({tag, "_data"}, exp);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check_eq({tag, "_araddr"}, araddr, {addr[31:2], 2'b00});
        end while (!mem_rvalid && cyc < 12);
        check_eq({tag, "_lat"}, cyc, 3);
        pop_check(mem_rdata);
        mem_to_reg = 0; rvalid = 0; arready = 0;
        @(negedge clk);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data, input logic [31:0] exp_wdata,
                            input logic [3:0] exp_wstrb);
        int cyc;
        awready = 1; wready = 1; bvalid = 1; bresp = 2'b11;
        alu_out = addr; func3 = f3; rs2 = data; write_mem = 1;
        push_exp({tag, "_wdata"}, exp_wdata);
        push_exp({tag, "_wstrb"}, {28'h0, exp_wstrb});
        push_exp({tag, "_awaddr"}, {addr[31:2], 2'b00});
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check_eq({tag, "_valids"}, {30'h0, awvalid, wvalid}, 32'h3);
                pop_check(wdata);
                pop_check({28'h0, wstrb});
                pop_check(awaddr);
            end
        end while (!mem_wready && cyc < 12);
        check_eq({tag, "_lat"}, cyc, 3);
        write_mem = 0; awready = 0; wready = 0; bvalid = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Reset state and no-request idle behaviour.
        check_eq("rst_rdata", mem_rdata, 32'h0);
        check_eq("rst_valids", {26'h0, arvalid, rready, awvalid, wvalid, bready, 1'b0}, 32'h0);
        check_eq("rst_addrs", araddr | awaddr, 32'h0);
        check_eq("rst_wdata", wdata, 32'h0);
        check_eq("rst_wstrb", {28'h0, wstrb}, 32'h0);
        check_eq("idle_handshake", {30'h0, mem_rvalid, mem_wready}, 32'h3);

        do_load("lb3",  32'h8000_0003, 3'b000, 32'h80FF_1234, 32'hFFFF_FF80);
        do_load("lbu3", 32'h8000_0003, 3'b100, 32'h80FF_1234, 32'h0000_0080);
        do_load("lb1",  32'h8000_0001, 3'b000, 32'h80FF_1234, 32'h0000_0012);
        do_load("lh2",  32'h8000_0002, 3'b001, 32'h80FF_1234, 32'hFFFF_80FF);
        do_load("lhu0", 32'h8000_0000, 3'b101, 32'h80FF_9234, 32'h0000_9234);
        do_load("lw",   32'h8000_0010, 3'b010, 32'h80FF_1234, 32'h80FF_1234);

        do_store("sh2", 32'h8000_0002, 3'b001, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100);
        do_store("sb1", 32'h8000_0001, 3'b000, 32'h1234_56AB, 32'hABAB_ABAB, 4'b0010);
        do_store("sb3", 32'h8000_0007, 3'b000, 32'h0000_0011, 32'h1111_1111, 4'b1000);
        do_store("sw",  32'h8000_0010, 3'b010, 32'h1234_5678, 32'h1234_5678, 4'b1111);

        // Delayed aw/w handshakes on different cycles.
        alu_out = 32'h8000_0104; func3 = 3'b010; rs2 = 32'hCAFE_F00D; write_mem = 1;
        push_exp("slow_wdata", 32'hCAFE_F00D);
        @(negedge clk);
        check_eq("slow_c1_valids", {30'h0, awvalid, wvalid}, 32'h3);
        pop_check(wdata);
        @(negedge clk);
        awready = 1;
        @(negedge clk);
        awready = 0;
        check_eq("slow_c3_valids", {30'h0, awvalid, wvalid}, 32'h1);
        @(negedge clk);
        check_eq("slow_c4_wv_bready", {30'h0, wvalid, bready}, 32'h2);
        @(negedge clk);
        wready = 1;
        @(negedge clk);
        wready = 0;
        check_eq("slow_c6_wv_bready", {30'h0, wvalid, bready}, 32'h1);
        check_eq("slow_c6_wready", {31'h0, mem_wready}, 32'h0);
        @(negedge clk);
        check_eq("slow_c7_wready", {31'h0, mem_wready}, 32'h0);
        bvalid = 1;
        @(negedge clk);
        bvalid = 0;
        check_eq("slow_c8_wready", {31'h0, mem_wready}, 32'h1);
        write_mem = 0;
        @(negedge clk);

        // Load and store together: the load is issued.
        arready = 1; rvalid = 1; rdata = 32'h0000_0055; alu_out = 32'h8000_0020;
        func3 = 3'b010; mem_to_reg = 1; write_mem = 1;
        @(negedge clk);
        check_eq("both_pick_load", {30'h0, arvalid, awvalid}, 32'h2);
        repeat (2) @(negedge clk);
        check_eq("both_data", mem_rdata, 32'h0000_0055);
        mem_to_reg = 0; write_mem = 0; arready = 0; rvalid = 0;
        @(negedge clk);

        // Completion held in DONE while stalled.
        stall = 1;
        arready = 1; rvalid = 1; rdata = 32'hFEDC_1234; alu_out = 32'h8000_0002;
        func3 = 3'b001; mem_to_reg = 1;
        push_exp("stall_data", 32'hFFFF_FEDC);
        repeat (3) @(negedge clk);
        check_eq("stall_rvalid", {31'h0, mem_rvalid}, 32'h1);
        pop_check(mem_rdata);
        rdata = 32'h0; arready = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall_hold%0d", i),
                     {mem_rdata[31:2], mem_rvalid, arvalid}, {30'h3FFF_FFB7, 1'b1, 1'b0});
        end
        stall = 0; mem_to_reg = 0; arready = 0; rvalid = 0;
        @(negedge clk);

        // Reset in RDATA, then a late rvalid.
        arready = 1; rvalid = 0; alu_out = 32'h8000_0000; func3 = 3'b010; mem_to_reg = 1;
        repeat (2) @(negedge clk);
        check_eq("rdata_state_rready", {31'h0, rready}, 32'h1);
        rst = 1;
        @(negedge clk);
        rst = 0; arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
        check_eq("midrst_rdata", mem_rdata, 32'h0);
        check_eq("midrst_rready", {31'h0, rready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("midrst_rvalid%0d", i), {31'h0, mem_rvalid}, 32'h0);
        end
        check_eq("midrst_rdata_after", mem_rdata, 32'h0);
        mem_to_reg = 0; rvalid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // No memory instruction: nothing issued.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq($sformatf("nomem%0d", i),
                     {27'h0, mem_rvalid, mem_wready, arvalid, awvalid, wvalid}, 32'h18);
        end

        check_eq("scoreboard_drained", q_exp.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
